// File: rtl/ls_buffer.sv
// Load/store buffer: circular queue of memory ops that snoops the CDBs,
// waits for store commit and issues in order from head to the memory controller.
module ls_buffer #(
    parameter int unsigned LSB_WIDTH = 4,
    parameter int unsigned ROB_WIDTH = 4,
    parameter int unsigned OP_WIDTH  = 6,
    parameter logic [OP_WIDTH-1:0] OP_SB = OP_WIDTH'(15),
    parameter logic [OP_WIDTH-1:0] OP_SH = OP_WIDTH'(16),
    parameter logic [OP_WIDTH-1:0] OP_SW = OP_WIDTH'(17)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   rdy_in,
    input  logic                   dispatch_valid_in,
    input  logic [OP_WIDTH-1:0]    dispatch_opcode_in,
    input  logic [31:0]            dispatch_imm_in,
    input  logic [31:0]            dispatch_vj_in,
    input  logic [31:0]            dispatch_vk_in,
    input  logic [ROB_WIDTH:0]     dispatch_qj_in,
    input  logic [ROB_WIDTH:0]     dispatch_qk_in,
    input  logic [ROB_WIDTH:0]     dispatch_rob_id_in,
    output logic                   full_out,
    input  logic                   rdy_alu_cdb_in,
    input  logic [ROB_WIDTH-1:0]   rob_id_alu_cdb_in,
    input  logic [31:0]            result_alu_cdb_in,
    input  logic                   rdy_ls_cdb_in,
    input  logic [ROB_WIDTH-1:0]   rob_id_ls_cdb_in,
    input  logic [31:0]            result_ls_cdb_in,
    input  logic                   commit_store_in,
    input  logic [ROB_WIDTH-1:0]   commit_rob_id_in,
    input  logic                   refresh_rob_cdb_in,
    input  logic                   idle_lsb_in,
    output logic                   rdy_lsb_out,
    output logic [OP_WIDTH-1:0]    opcode_lsb_out,
    output logic [31:0]            vj_lsb_out,
    output logic [31:0]            vk_lsb_out,
    output logic [31:0]            imm_lsb_out,
    output logic [ROB_WIDTH:0]     rob_id_lsb_out
);

    localparam int unsigned DEPTH = 1 << LSB_WIDTH;
    localparam int unsigned CNT_W = LSB_WIDTH + 1;

    logic [LSB_WIDTH-1:0] head, tail;
    logic [CNT_W-1:0]     count;
    logic [DEPTH-1:0]     busy, committed;

    logic [OP_WIDTH-1:0]  opcode_q [DEPTH];
    logic [31:0]          imm_q    [DEPTH];
    logic [31:0]          vj_q     [DEPTH];
    logic [31:0]          vk_q     [DEPTH];
    logic [ROB_WIDTH:0]   qj_q     [DEPTH];
    logic [ROB_WIDTH:0]   qk_q     [DEPTH];
    logic [ROB_WIDTH:0]   rob_id_q [DEPTH];

    logic                 do_dispatch, do_issue, head_ready;
    logic [CNT_W-1:0]     kept;
    logic [31:0]          disp_vj, disp_vk;
    logic [ROB_WIDTH:0]   disp_qj, disp_qk;

    function automatic logic is_store(input logic [OP_WIDTH-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic cdb_hit(input logic [ROB_WIDTH:0] q, input logic vld,
                                     input logic [ROB_WIDTH-1:0] tag);
        return vld && q[ROB_WIDTH] && (q[ROB_WIDTH-1:0] == tag);
    endfunction

    // Issue/dispatch qualification, refresh survivor count, same-cycle CDB capture
    always_comb begin
        full_out    = (count == CNT_W'(DEPTH));
        head_ready  = busy[head] && !qj_q[head][ROB_WIDTH] &&
                      (!is_store(opcode_q[head]) || (!qk_q[head][ROB_WIDTH] && committed[head]));
        do_issue    = rdy_in && !refresh_rob_cdb_in && idle_lsb_in && !rdy_lsb_out && head_ready;
        do_dispatch = rdy_in && !refresh_rob_cdb_in && dispatch_valid_in && !full_out;
        kept = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            kept = kept + CNT_W'(busy[i] & committed[i]);
        end
        disp_vj = dispatch_vj_in;
        disp_qj = dispatch_qj_in;
        if (cdb_hit(dispatch_qj_in, rdy_alu_cdb_in, rob_id_alu_cdb_in)) begin
            disp_vj = result_alu_cdb_in;
            disp_qj = '0;
        end else if (cdb_hit(dispatch_qj_in, rdy_ls_cdb_in, rob_id_ls_cdb_in)) begin
            disp_vj = result_ls_cdb_in;
            disp_qj = '0;
        end
        disp_vk = dispatch_vk_in;
        disp_qk = dispatch_qk_in;
        if (cdb_hit(dispatch_qk_in, rdy_alu_cdb_in, rob_id_alu_cdb_in)) begin
            disp_vk = result_alu_cdb_in;
            disp_qk = '0;
        end else if (cdb_hit(dispatch_qk_in, rdy_ls_cdb_in, rob_id_ls_cdb_in)) begin
            disp_vk = result_ls_cdb_in;
            disp_qk = '0;
        end
    end

    // Entry payload: CDB snooping and dispatch writes (validity lives in busy)
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (busy[i]) begin
                    if (cdb_hit(qj_q[i], rdy_alu_cdb_in, rob_id_alu_cdb_in)) begin
                        vj_q[i] <= result_alu_cdb_in;
                        qj_q[i] <= '0;
                    end else if (cdb_hit(qj_q[i], rdy_ls_cdb_in, rob_id_ls_cdb_in)) begin
                        vj_q[i] <= result_ls_cdb_in;
                        qj_q[i] <= '0;
                    end
                    if (cdb_hit(qk_q[i], rdy_alu_cdb_in, rob_id_alu_cdb_in)) begin
                        vk_q[i] <= result_alu_cdb_in;
                        qk_q[i] <= '0;
                    end else if (cdb_hit(qk_q[i], rdy_ls_cdb_in, rob_id_ls_cdb_in)) begin
                        vk_q[i] <= result_ls_cdb_in;
                        qk_q[i] <= '0;
                    end
                end
            end
            if (do_dispatch) begin
                opcode_q[tail] <= dispatch_opcode_in;
                imm_q[tail]    <= dispatch_imm_in;
                vj_q[tail]     <= disp_vj;
                vk_q[tail]     <= disp_vk;
                qj_q[tail]     <= disp_qj;
                qk_q[tail]     <= disp_qk;
                rob_id_q[tail] <= dispatch_rob_id_in;
            end
        end
    end

    // Queue control, commit marking, flush and issue payload
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            busy           <= '0;
            committed      <= '0;
            rdy_lsb_out    <= 1'b0;
            opcode_lsb_out <= '0;
            vj_lsb_out     <= '0;
            vk_lsb_out     <= '0;
            imm_lsb_out    <= '0;
            rob_id_lsb_out <= '0;
        end else if (rdy_in) begin
            rdy_lsb_out <= do_issue;
            if (refresh_rob_cdb_in) begin
                // surviving committed stores are contiguous from head
                busy      <= busy & committed;
                committed <= busy & committed;
                tail      <= head + kept[LSB_WIDTH-1:0];
                count     <= kept;
            end else begin
                if (commit_store_in) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (busy[i] && is_store(opcode_q[i]) &&
                            rob_id_q[i][ROB_WIDTH-1:0] == commit_rob_id_in)
                            committed[i] <= 1'b1;
                    end
                end
                if (do_dispatch) begin
                    busy[tail]      <= 1'b1;
                    committed[tail] <= 1'b0;
                    tail            <= tail + LSB_WIDTH'(1);
                end
                if (do_issue) begin
                    busy[head]      <= 1'b0;
                    committed[head] <= 1'b0;
                    head            <= head + LSB_WIDTH'(1);
                    opcode_lsb_out  <= opcode_q[head];
                    vj_lsb_out      <= vj_q[head];
                    vk_lsb_out      <= vk_q[head];
                    imm_lsb_out     <= imm_q[head];
                    rob_id_lsb_out  <= rob_id_q[head];
                end
                if (do_dispatch && !do_issue)
                    count <= count + CNT_W'(1);
                else if (!do_dispatch && do_issue)
                    count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ls_buffer.sv
// Directed bench for ls_buffer: issue, store commit, CDB forwarding, full/wrap, flush, reset.
module tb_ls_buffer;

    localparam logic [5:0] OP_LW = 6'd12;
    localparam logic [5:0] OP_SW = 6'd17;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, dispatch_valid_in;
    logic [5:0]  dispatch_opcode_in;
    logic [31:0] dispatch_imm_in, dispatch_vj_in, dispatch_vk_in;
    logic [4:0]  dispatch_qj_in, dispatch_qk_in, dispatch_rob_id_in;
    logic        full_out;
    logic        rdy_alu_cdb_in, rdy_ls_cdb_in, commit_store_in, refresh_rob_cdb_in, idle_lsb_in;
    logic [3:0]  rob_id_alu_cdb_in, rob_id_ls_cdb_in, commit_rob_id_in;
    logic [31:0] result_alu_cdb_in, result_ls_cdb_in;
    logic        rdy_lsb_out;
    logic [5:0]  opcode_lsb_out;
    logic [31:0] vj_lsb_out, vk_lsb_out, imm_lsb_out;
    logic [4:0]  rob_id_lsb_out;

    int tests = 0;
    int fails = 0;
    logic seen;

    ls_buffer dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .dispatch_valid_in(dispatch_valid_in), .dispatch_opcode_in(dispatch_opcode_in),
        .dispatch_imm_in(dispatch_imm_in), .dispatch_vj_in(dispatch_vj_in),
        .dispatch_vk_in(dispatch_vk_in), .dispatch_qj_in(dispatch_qj_in),
        .dispatch_qk_in(dispatch_qk_in), .dispatch_rob_id_in(dispatch_rob_id_in),
        .full_out(full_out),
        .rdy_alu_cdb_in(rdy_alu_cdb_in), .rob_id_alu_cdb_in(rob_id_alu_cdb_in),
        .result_alu_cdb_in(result_alu_cdb_in),
        .rdy_ls_cdb_in(rdy_ls_cdb_in), .rob_id_ls_cdb_in(rob_id_ls_cdb_in),
        .result_ls_cdb_in(result_ls_cdb_in),
        .commit_store_in(commit_store_in), .commit_rob_id_in(commit_rob_id_in),
        .refresh_rob_cdb_in(refresh_rob_cdb_in), .idle_lsb_in(idle_lsb_in),
        .rdy_lsb_out(rdy_lsb_out), .opcode_lsb_out(opcode_lsb_out),
        .vj_lsb_out(vj_lsb_out), .vk_lsb_out(vk_lsb_out), .imm_lsb_out(imm_lsb_out),
        .rob_id_lsb_out(rob_id_lsb_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] vj,
                        input logic [31:0] vk, input logic [4:0] qj, input logic [4:0] qk,
                        input logic [4:0] rob);
        dispatch_valid_in  = 1'b1;
        dispatch_opcode_in = op;
        dispatch_imm_in    = imm;
        dispatch_vj_in     = vj;
        dispatch_vk_in     = vk;
        dispatch_qj_in     = qj;
        dispatch_qk_in     = qk;
        dispatch_rob_id_in = rob;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        step();
        step();
        rst_n_in = 1'b1;
        step();
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; dispatch_valid_in = 1'b0;
        dispatch_opcode_in = '0; dispatch_imm_in = '0; dispatch_vj_in = '0; dispatch_vk_in = '0;
        dispatch_qj_in = '0; dispatch_qk_in = '0; dispatch_rob_id_in = '0;
        rdy_alu_cdb_in = 1'b0; rob_id_alu_cdb_in = '0; result_alu_cdb_in = '0;
        rdy_ls_cdb_in = 1'b0; rob_id_ls_cdb_in = '0; result_ls_cdb_in = '0;
        commit_store_in = 1'b0; commit_rob_id_in = '0; refresh_rob_cdb_in = 1'b0;
        idle_lsb_in = 1'b1;
        step();
        step();
        chk("reset_rdy", 64'(rdy_lsb_out), 64'd0);
        chk("reset_full", 64'(full_out), 64'd0);
        chk("reset_count", 64'(dut.count), 64'd0);
        rst_n_in = 1'b1;
        step();

        // Simple load issues one cycle after it lands
        disp(OP_LW, 32'd4, 32'h100, 32'h0, 5'h00, 5'h00, 5'd1);
        step();
        dispatch_valid_in = 1'b0;
        chk("lw_count1", 64'(dut.count), 64'd1);
        chk("lw_no_strobe_yet", 64'(rdy_lsb_out), 64'd0);
        step();
        chk("lw_strobe", 64'(rdy_lsb_out), 64'd1);
        chk("lw_opcode", 64'(opcode_lsb_out), 64'(OP_LW));
        chk("lw_vj", 64'(vj_lsb_out), 64'h100);
        chk("lw_imm", 64'(imm_lsb_out), 64'd4);
        chk("lw_rob", 64'(rob_id_lsb_out), 64'd1);
        chk("lw_count0", 64'(dut.count), 64'd0);
        step();
        chk("lw_pulse_one_cycle", 64'(rdy_lsb_out), 64'd0);
        chk("lw_payload_hold", 64'(vj_lsb_out), 64'h100);

        // Store waits for commit
        disp(OP_SW, 32'd8, 32'h200, 32'h55, 5'h00, 5'h00, 5'd2);
        step();
        dispatch_valid_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | rdy_lsb_out;
        end
        chk("sw_no_strobe_uncommitted", 64'(seen), 64'd0);
        commit_store_in = 1'b1; commit_rob_id_in = 4'd2;
        step();
        commit_store_in = 1'b0;
        chk("sw_commit_edge_no_strobe", 64'(rdy_lsb_out), 64'd0);
        step();
        chk("sw_strobe", 64'(rdy_lsb_out), 64'd1);
        chk("sw_opcode", 64'(opcode_lsb_out), 64'(OP_SW));
        chk("sw_vk", 64'(vk_lsb_out), 64'h55);

        // CDB forwarding into a queued entry and at dispatch
        idle_lsb_in = 1'b0;
        disp(OP_LW, 32'd0, 32'h0, 32'h0, 5'b10011, 5'h00, 5'd4);
        step();
        dispatch_valid_in = 1'b0;
        step();
        rdy_alu_cdb_in = 1'b1; rob_id_alu_cdb_in = 4'd3; result_alu_cdb_in = 32'h2000;
        step();
        rdy_alu_cdb_in = 1'b0;
        disp(OP_LW, 32'd0, 32'h0, 32'h0, 5'b10101, 5'h00, 5'd5);
        rdy_ls_cdb_in = 1'b1; rob_id_ls_cdb_in = 4'd5; result_ls_cdb_in = 32'h3000;
        step();
        dispatch_valid_in = 1'b0; rdy_ls_cdb_in = 1'b0;
        chk("fwd_held_not_idle", 64'(rdy_lsb_out), 64'd0);
        idle_lsb_in = 1'b1;
        step();
        chk("fwd_alu_strobe", 64'(rdy_lsb_out), 64'd1);
        chk("fwd_alu_vj", 64'(vj_lsb_out), 64'h2000);
        chk("fwd_alu_rob", 64'(rob_id_lsb_out), 64'd4);
        step();
        chk("no_back_to_back", 64'(rdy_lsb_out), 64'd0);
        step();
        chk("fwd_disp_vj", 64'(vj_lsb_out), 64'h3000);
        chk("fwd_disp_rob", 64'(rob_id_lsb_out), 64'd5);
        idle_lsb_in = 1'b0;
        step();

        // Fill to full, drop overflow, wrap tail
        do_reset();
        for (int i = 0; i < 16; i++) begin
            disp(OP_LW, 32'd0, 32'h1000 + 32'(i), 32'h0, 5'h00, 5'h00, 5'(i));
            step();
        end
        chk("full_flag", 64'(full_out), 64'd1);
        chk("full_count", 64'(dut.count), 64'd16);
        chk("full_tail_wrap", 64'(dut.tail), 64'd0);
        disp(OP_LW, 32'd0, 32'hDEAD, 32'h0, 5'h00, 5'h00, 5'd9);
        step();
        chk("overflow_dropped", 64'(dut.count), 64'd16);
        chk("overflow_tail", 64'(dut.tail), 64'd0);
        disp(OP_LW, 32'd0, 32'hBEEF, 32'h0, 5'h00, 5'h00, 5'd9);
        idle_lsb_in = 1'b1;
        step();
        chk("full_issue_strobe", 64'(rdy_lsb_out), 64'd1);
        chk("full_issue_vj", 64'(vj_lsb_out), 64'h1000);
        chk("full_disp_ignored", 64'(dut.count), 64'd15);
        dispatch_valid_in = 1'b0; idle_lsb_in = 1'b0;
        step();
        disp(OP_LW, 32'd0, 32'h5555, 32'h0, 5'h00, 5'h00, 5'd9);
        idle_lsb_in = 1'b1;
        step();
        dispatch_valid_in = 1'b0; idle_lsb_in = 1'b0;
        chk("simul_count_same", 64'(dut.count), 64'd15);
        chk("simul_tail", 64'(dut.tail), 64'd1);
        chk("simul_vj", 64'(vj_lsb_out), 64'h1001);

        // Flush keeps the committed store at head
        do_reset();
        disp(OP_SW, 32'd0, 32'h40, 32'h99, 5'h00, 5'h00, 5'd1);
        step();
        disp(OP_LW, 32'd0, 32'h0, 32'h0, 5'h00, 5'h00, 5'd2);
        commit_store_in = 1'b1; commit_rob_id_in = 4'd1;
        step();
        commit_store_in = 1'b0;
        disp(OP_LW, 32'd0, 32'h0, 32'h0, 5'h00, 5'h00, 5'd3);
        step();
        chk("pre_flush_count", 64'(dut.count), 64'd3);
        disp(OP_LW, 32'd0, 32'h0, 32'h0, 5'h00, 5'h00, 5'd6);
        refresh_rob_cdb_in = 1'b1;
        step();
        refresh_rob_cdb_in = 1'b0; dispatch_valid_in = 1'b0;
        chk("flush_count", 64'(dut.count), 64'd1);
        chk("flush_tail", 64'(dut.tail), 64'd1);
        chk("flush_no_strobe", 64'(rdy_lsb_out), 64'd0);
        idle_lsb_in = 1'b1;
        step();
        chk("flush_sw_strobe", 64'(rdy_lsb_out), 64'd1);
        chk("flush_sw_rob", 64'(rob_id_lsb_out), 64'd1);
        chk("flush_sw_vk", 64'(vk_lsb_out), 64'h99);

        // Reset during an issue strobe
        disp(OP_LW, 32'd8, 32'hABC, 32'h0, 5'h00, 5'h00, 5'd7);
        step();
        dispatch_valid_in = 1'b0;
        step();
        chk("pre_reset_strobe", 64'(rdy_lsb_out), 64'd1);
        rst_n_in = 1'b0;
        #1;
        chk("async_rst_rdy", 64'(rdy_lsb_out), 64'd0);
        chk("async_rst_vj", 64'(vj_lsb_out), 64'd0);
        chk("async_rst_op", 64'(opcode_lsb_out), 64'd0);
        chk("async_rst_count", 64'(dut.count), 64'd0);
        chk("async_rst_full", 64'(full_out), 64'd0);
        step();
        rst_n_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | rdy_lsb_out;
        end
        chk("post_rst_quiet", 64'(seen), 64'd0);
        disp(OP_LW, 32'd0, 32'h77, 32'h0, 5'h00, 5'h00, 5'd2);
        step();
        dispatch_valid_in = 1'b0;
        step();
        chk("post_rst_strobe", 64'(rdy_lsb_out), 64'd1);
        chk("post_rst_vj", 64'(vj_lsb_out), 64'h77);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
